// File: rtl/match_scoreboard_if.sv
// rtl/match_scoreboard_if.sv - match scoreboard control/result bundle between game stage and scoreboard
interface match_scoreboard_if #(
    parameter int N       = 4,
    parameter int SCORE_W = 4
) ();
    logic               start;
    logic               gameover;
    logic [1:0]         who;
    logic               init;
    logic [N-1:0]       initial_val;
    logic [SCORE_W-1:0] win_score;
    logic [SCORE_W-1:0] lose_score;
    logic [SCORE_W-1:0] rounds_played;
    logic               busy;
    logic               match_over;
    logic [1:0]         match_winner;

    modport master (
        output start, gameover, who,
        input  init, initial_val, win_score, lose_score, rounds_played,
               busy, match_over, match_winner
    );

    modport slave (
        input  start, gameover, who,
        output init, initial_val, win_score, lose_score, rounds_played,
               busy, match_over, match_winner
    );
endinterface

// File: rtl/match_scoreboard.sv
// rtl/match_scoreboard.sv - best-of match tally with per-round re-arm; MATCH_SCOREBOARD_LFSR_SEED_EN selects LFSR start values
module match_scoreboard #(
    parameter int           N             = 4,
    parameter int           SCORE_W       = 4,
    parameter int           ROUNDS_TO_WIN = 3,
    parameter logic [N-1:0] SEED          = 'h8
) (
    input  logic                 clk,
    input  logic                 rst,
    match_scoreboard_if.slave    bus
);
    localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(ROUNDS_TO_WIN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_PLAY,
        S_TALLY,
        S_DONE
    } state_t;

    state_t             state;
    logic               gameover_q;
    logic [1:0]         who_q;
    logic               go_rise;
    logic               who_valid;
    logic [SCORE_W-1:0] win_next;
    logic [SCORE_W-1:0] lose_next;
    logic [SCORE_W-1:0] rounds_next;
    logic               decided;
    logic               start_match;
    logic               arm_now;
    logic [N-1:0]       arm_val;

    assign go_rise   = bus.gameover & ~gameover_q;
    assign who_valid = (bus.who == 2'd1) || (bus.who == 2'd2);

    always_comb begin
        win_next  = bus.win_score;
        lose_next = bus.lose_score;
        if (who_q == 2'd2) begin
            win_next = bus.win_score + 1'b1;
        end else begin
            lose_next = bus.lose_score + 1'b1;
        end
        rounds_next = (&bus.rounds_played) ? bus.rounds_played : bus.rounds_played + 1'b1;
        decided     = (win_next == TARGET) || (lose_next == TARGET);
    end

    assign start_match = ((state == S_IDLE) || (state == S_DONE)) && bus.start;
    assign arm_now     = start_match || ((state == S_TALLY) && !decided);

`ifdef MATCH_SCOREBOARD_LFSR_SEED_EN
    function automatic logic [N-1:0] lfsr_taps();
        case (N)
            2:       return N'('b11);
            3:       return N'('b110);
            5:       return N'('b10100);
            6:       return N'('b110000);
            7:       return N'('b1100000);
            8:       return N'('b10111000);
            default: return N'('b1100);
        endcase
    endfunction

    localparam logic [N-1:0] TAPS = lfsr_taps();

    logic [N-1:0] lfsr;

    // A start value of 0 or all-ones would leave the game already decided.
    assign arm_val = ((lfsr == '0) || (lfsr == '1)) ? SEED : lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= SEED;
        end else if (arm_now) begin
            lfsr <= {lfsr[N-2:0], ^(lfsr & TAPS)};
        end
    end
`else
    assign arm_val = SEED;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.init        <= 1'b0;
            bus.initial_val <= SEED;
        end else begin
            bus.init <= arm_now;
            if (arm_now) begin
                bus.initial_val <= arm_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            gameover_q        <= 1'b0;
            who_q             <= 2'd0;
            bus.win_score     <= '0;
            bus.lose_score    <= '0;
            bus.rounds_played <= '0;
            bus.busy          <= 1'b0;
            bus.match_over    <= 1'b0;
            bus.match_winner  <= 2'd0;
        end else begin
            gameover_q <= bus.gameover;
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state             <= S_ARM;
                        bus.win_score     <= '0;
                        bus.lose_score    <= '0;
                        bus.rounds_played <= '0;
                        bus.busy          <= 1'b1;
                        bus.match_over    <= 1'b0;
                        bus.match_winner  <= 2'd0;
                    end
                end
                S_ARM: begin
                    state <= S_PLAY;
                end
                S_PLAY: begin
                    // A rising edge carrying no result is a void round: keep waiting.
                    if (go_rise && who_valid) begin
                        who_q <= bus.who;
                        state <= S_TALLY;
                    end
                end
                S_TALLY: begin
                    bus.win_score     <= win_next;
                    bus.lose_score    <= lose_next;
                    bus.rounds_played <= rounds_next;
                    if (decided) begin
                        state            <= S_DONE;
                        bus.busy         <= 1'b0;
                        bus.match_over   <= 1'b1;
                        bus.match_winner <= who_q;
                    end else begin
                        state <= S_ARM;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_match_scoreboard.sv
// tb/tb_match_scoreboard.sv - directed bench for match_scoreboard with a phase-level reference model
module tb_match_scoreboard;
    localparam logic [3:0] SEED = 4'h8;
    localparam int         R    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    match_scoreboard_if #(.N(4), .SCORE_W(4)) bus ();

    match_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    // Start values of x^4+x^3+1 from 4'h8, with the all-ones state replaced by SEED.
    logic [3:0] lfsr_tab [15] = '{4'h8, 4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD,
                                  4'hA, 4'h5, 4'hB, 4'h7, 4'h8, 4'hE, 4'hC};

    typedef enum {P_IDLE, P_ARM, P_PLAY, P_TALLY, P_DONE} phase_t;
    phase_t     ph       = P_IDLE;
    int         m_win    = 0;
    int         m_lose   = 0;
    int         m_rounds = 0;
    int         m_winner = 0;
    int         m_who    = 0;
    int         m_arms   = 0;
    bit         m_over   = 1'b0;
    bit         m_init   = 1'b0;
    bit         m_go_q   = 1'b0;
    bit         started  = 1'b0;
    bit         prev_init = 1'b0;
    logic [3:0] m_ival   = SEED;

    function automatic void enter_arm();
        ph     = P_ARM;
        m_init = 1'b1;
`ifdef MATCH_SCOREBOARD_LFSR_SEED_EN
        m_ival = lfsr_tab[m_arms % 15];
`else
        m_ival = SEED;
`endif
        m_arms++;
    endfunction

    always @(posedge clk) begin : model
        bit rise;
        rise   = bus.gameover && !m_go_q;
        m_go_q = bus.gameover;
        m_init = 1'b0;
        if (rst) begin
            ph = P_IDLE;
            m_win = 0; m_lose = 0; m_rounds = 0; m_winner = 0;
            m_over = 1'b0; m_ival = SEED; m_arms = 0; m_go_q = 1'b0;
        end else begin
            case (ph)
                P_IDLE, P_DONE: if (bus.start) begin
                    m_win = 0; m_lose = 0; m_rounds = 0; m_over = 1'b0; m_winner = 0;
                    enter_arm();
                end
                P_ARM: ph = P_PLAY;
                P_PLAY: if (rise && (bus.who == 2'd1 || bus.who == 2'd2)) begin
                    m_who = int'(bus.who);
                    ph    = P_TALLY;
                end
                P_TALLY: begin
                    if (m_who == 2) m_win++; else m_lose++;
                    if (m_rounds < 15) m_rounds++;
                    if (m_win == R || m_lose == R) begin
                        ph = P_DONE; m_over = 1'b1; m_winner = m_who;
                    end else begin
                        enter_arm();
                    end
                end
                default: ph = P_IDLE;
            endcase
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("init", bus.init, m_init);
            chk("initial_val", bus.initial_val, m_ival);
            chk("win_score", bus.win_score, m_win);
            chk("lose_score", bus.lose_score, m_lose);
            chk("rounds_played", bus.rounds_played, m_rounds);
            chk("busy", bus.busy, (ph == P_ARM || ph == P_PLAY || ph == P_TALLY));
            chk("match_over", bus.match_over, m_over);
            chk("match_winner", bus.match_winner, m_winner);
            chk("init_back_to_back", bus.init & prev_init, 0);
            prev_init = bus.init;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic start_match();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    // Enters in ARM; returns after the edge that leaves TALLY (third cycle of the round).
    task automatic round(input logic [1:0] w, output bit armed);
        tick(1);
        bus.gameover = 1'b1;
        bus.who      = w;
        tick(1);
        bus.gameover = 1'b0;
        bus.who      = 2'd0;
        tick(1);
        armed = bus.init;
    endtask

    initial begin
        bit         armed;
        logic [1:0] seq3 [5] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
        logic [3:0] iv;
        bus.start = 1'b0; bus.gameover = 1'b0; bus.who = 2'd0;
        rst = 1'b1;
        tick(2);
        chk("rst_init", bus.init, 0);
        chk("rst_initial_val", bus.initial_val, 4'h8);
        chk("rst_busy", bus.busy, 0);
        chk("rst_match_over", bus.match_over, 0);
        rst = 1'b0;
        tick(1);

        start_match();
        chk("t1_init", bus.init, 1);
        chk("t1_initial_val", bus.initial_val, 4'h8);
        chk("t1_busy", bus.busy, 1);
        chk("t1_win_score", bus.win_score, 0);
        for (int i = 1; i <= 3; i++) begin
            round(2'd2, armed);
            chk("t2_win_score", bus.win_score, i);
            chk("t2_rearm", armed, (i < 3));
        end
        chk("t2_match_over", bus.match_over, 1);
        chk("t2_match_winner", bus.match_winner, 2);
        chk("t2_rounds_played", bus.rounds_played, 3);
        chk("t2_busy", bus.busy, 0);
        tick(3);
        chk("t2_no_fourth_init", bus.init, 0);

        start_match();
        chk("t3_cleared_over", bus.match_over, 0);
        chk("t3_cleared_win", bus.win_score, 0);
        for (int i = 0; i < 5; i++) begin
            round(seq3[i], armed);
            chk("t3_latency3_init", armed, (i < 4));
        end
        chk("t3_lose_score", bus.lose_score, 3);
        chk("t3_win_score", bus.win_score, 2);
        chk("t3_rounds_played", bus.rounds_played, 5);
        chk("t3_match_winner", bus.match_winner, 1);

        start_match();
        tick(1);
        bus.gameover = 1'b1; bus.who = 2'd2;
        tick(5);
        bus.gameover = 1'b0; bus.who = 2'd0;
        chk("t4_held_win", bus.win_score, 1);
        chk("t4_held_rounds", bus.rounds_played, 1);
        bus.gameover = 1'b1;
        tick(1);
        bus.gameover = 1'b0;
        tick(2);
        chk("t4_void_win", bus.win_score, 1);
        chk("t4_void_lose", bus.lose_score, 0);
        chk("t4_void_busy", bus.busy, 1);
        bus.gameover = 1'b1; bus.who = 2'd2;
        tick(1);
        bus.gameover = 1'b0; bus.who = 2'd0;
        tick(1);
        chk("t4_still_play_rearm", bus.init, 1);
        chk("t4_win_two", bus.win_score, 2);

        tick(1);
        rst = 1'b1; bus.gameover = 1'b1; bus.who = 2'd2;
        tick(1);
        rst = 1'b0; bus.gameover = 1'b0; bus.who = 2'd0;
        chk("t5_win_score", bus.win_score, 0);
        chk("t5_rounds", bus.rounds_played, 0);
        chk("t5_busy", bus.busy, 0);
        chk("t5_init", bus.init, 0);
        tick(2);
        start_match();
        chk("t5_fresh_init", bus.init, 1);
        round(2'd1, armed);
        chk("t5_fresh_lose", bus.lose_score, 1);
        chk("t5_fresh_rounds", bus.rounds_played, 1);

        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (!bus.busy) start_match();
            chk("t6_init", bus.init, 1);
            iv = bus.initial_val;
            chk("t6_value_legal", (iv != 4'h0) && (iv != 4'hF), 1);
            if (k == 0) chk("t6_first_value", iv, 4'h8);
            round((k % 2 == 1) ? 2'd1 : 2'd2, armed);
        end
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
